bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 98 +++++++++
 tb/tb_bit_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with a one-word hold buffer; frames go out MSB first, back to back.
// Build option: define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             data_out,
  output logic             data_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] hreg_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic             accept;
  logic             frame_end;
  logic             load;
  logic             shift_bit;

  assign accept    = in_valid && !hold_full_q;
  assign frame_end = (state_q == SHIFT) && (cnt_q == LAST);
  // Hold-to-shift transfer: from IDLE, or seamlessly at the last bit of a running frame.
  assign load      = hold_full_q && ((state_q == IDLE) || frame_end);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hreg_q      <= '0;
      sreg_q      <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        hreg_q      <= in_data;
        hold_full_q <= 1'b1;
      end
      if (load) begin
        sreg_q      <= hreg_q;
        hold_full_q <= 1'b0;
        cnt_q       <= '0;
        state_q     <= SHIFT;
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          SHIFT: begin
            sreg_q <= sreg_q << 1;
            if (frame_end) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef BIT_SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     par_q <= 1'b0;
    else if (load) par_q <= ^hreg_q;
  end

  // After WIDTH data bits the counter points at the trailing parity slot.
  assign shift_bit = (cnt_q == CW'(WIDTH)) ? par_q : sreg_q[WIDTH-1];
`else
  assign shift_bit = sreg_q[WIDTH-1];
`endif

  assign in_ready    = !hold_full_q;
  assign data_valid  = (state_q == SHIFT);
  assign data_out    = (state_q == SHIFT) ? shift_bit : IDLE_LEVEL;
  assign frame_start = (state_q == SHIFT) && (cnt_q == '0);
  assign busy        = (state_q == SHIFT) || hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: vector table plus hand sequences, scoreboard of expected serial bits.
module tb_bit_serializer;
  localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int FR = W + 1;
`else
  localparam int FR = W;
`endif

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready, data_out, data_valid, frame_start, busy;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(W), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .data_valid(data_valid), .frame_start(frame_start), .busy(busy)
  );

  typedef struct { logic b; logic fs; } exp_bit_t;
  typedef struct { logic [W-1:0] word; int gap; logic [FR-1:0] exp; } vec_t;

  exp_bit_t sbq[$];
  exp_bit_t e_mon;
  int checks = 0, failures = 0;
  int cyc = 0, run_len = 0, max_run = 0, fs_cnt = 0, last_fs_cyc = 0, fs_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FR-1:0] model(input logic [W-1:0] w);
`ifdef BIT_SERIALIZER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic push_frame(input logic [FR-1:0] f);
    for (int i = FR - 1; i >= 0; i--) sbq.push_back('{f[i], (i == FR - 1)});
  endtask

  // Present a word, hold it while in_ready is low, push its frame once accepted.
  task automatic send(input logic [W-1:0] w, input logic [FR-1:0] f, output int waited);
    waited = 0;
    @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    push_frame(f);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || sbq.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_sb_empty", sbq.size(), 0);
    chk("drain_not_busy", busy, 0);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn) begin
      if (data_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (frame_start) begin
          fs_cnt++;
          fs_gap = cyc - last_fs_cyc;
          last_fs_cyc = cyc;
        end
        if (sbq.size() == 0) chk("unexpected_bit", 1, 0);
        else begin
          e_mon = sbq.pop_front();
          chk("data_out", data_out, e_mon.b);
          chk("frame_start", frame_start, e_mon.fs);
        end
      end else begin
        run_len = 0;
        chk("idle_level", data_out, 0);
        chk("idle_frame_start", frame_start, 0);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t vt[$];
    int   w1, w2, w3, n;
`ifdef BIT_SERIALIZER_PARITY_EN
    vt.push_back('{8'h07, 2, 9'b000001111});
    vt.push_back('{8'h03, 0, 9'b000000110});
    vt.push_back('{8'hFF, 1, 9'b111111110});
    vt.push_back('{8'h01, 3, 9'b000000011});
    vt.push_back('{8'hA5, 0, 9'b101001010});
`else
    vt.push_back('{8'hA5, 2, 8'b10100101});
    vt.push_back('{8'hF0, 0, 8'b11110000});
    vt.push_back('{8'h0F, 3, 8'b00001111});
    vt.push_back('{8'h00, 1, 8'b00000000});
    vt.push_back('{8'hFF, 0, 8'b11111111});
    vt.push_back('{8'h81, 0, 8'b10000001});
    vt.push_back('{8'h3C, 2, 8'b00111100});
`endif

    // Reset state before any clock edge
    #2;
    chk("rst_data_out", data_out, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single word: accept at N, first bit after N+1
    send(8'hA5, model(8'hA5), w1);
    @(negedge clk);
    chk("lat_dv_after_accept", data_valid, 0);
    chk("lat_busy_held", busy, 1);
    chk("lat_in_ready_low", in_ready, 0);
    @(negedge clk);
    chk("lat_first_dv", data_valid, 1);
    chk("lat_first_fs", frame_start, 1);
    chk("lat_first_bit", data_out, 1);
    drain();

    // Vector table
    foreach (vt[i]) begin
      send(vt[i].word, vt[i].exp, w1);
      repeat (vt[i].gap) @(negedge clk);
    end
    drain();

    // Streaming: two words, contiguous frames
    max_run = 0;
    fs_cnt  = 0;
    send(8'hF0, model(8'hF0), w1);
    send(8'h0F, model(8'h0F), w2);
    drain();
    chk("stream_contiguous", max_run, 2 * FR);
    chk("stream_fs_count", fs_cnt, 2);
    chk("stream_fs_spacing", fs_gap, FR);

    // Backpressure: third word must wait while the hold register is full
    send(8'hF0, model(8'hF0), w1);
    send(8'h3C, model(8'h3C), w2);
    send(8'h5A, model(8'h5A), w3);
    chk("bp_waited_on_ready", (w3 > 0), 1);
    drain();

    // Mid-frame reset with a held word pending
    send(8'hFF, model(8'hFF), w1);
    send(8'h81, model(8'h81), w2);
    n = 0;
    while (sbq.size() > 2 * FR - 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached_bit4", sbq.size(), 2 * FR - 4);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_data_out", data_out, 0);
    chk("mid_rst_data_valid", data_valid, 0);
    chk("mid_rst_frame_start", frame_start, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    sbq.delete();
    @(posedge clk);
    #2 rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_quiet_dv", data_valid, 0);
      chk("post_rst_quiet_bit", data_out, 0);
    end
    send(8'hC3, model(8'hC3), w1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
